// File: rtl/alu_pkg.sv
// Shared encodings for compare/branch logic: condition codes and flag bit positions.
package alu_pkg;

  localparam logic [2:0] CMP_NE  = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LE  = 3'b110;
  localparam logic [2:0] CMP_GT  = 3'b111;

  localparam int unsigned CMP_UNS_BIT = 3;

  localparam int unsigned F_N = 3;
  localparam int unsigned F_Z = 2;
  localparam int unsigned F_C = 1;
  localparam int unsigned F_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cmp_cond_eval.sv
// Combinational condition evaluator: {N,Z,C,V} flags plus condition code -> 1-bit result.
module cmp_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] fun,
  output logic       res
);

  logic n, z, c, v;
  logic lt;

  always_comb begin
    n  = flags[F_N];
    z  = flags[F_Z];
    c  = flags[F_C];
    v  = flags[F_V];
    // Unsigned "less than" is a borrow, i.e. no carry out of a + ~b + 1.
    lt = fun[CMP_UNS_BIT] ? ~c : (n ^ v);
  end

  always_comb begin
    res = 1'b0;
    case (fun[2:0])
      CMP_NE:          res = ~z;
      CMP_EQ:          res = z;
      CMP_LT, CMP_LTZ: res = lt;
      CMP_LE:          res = lt | z;
      CMP_GT:          res = ~lt & ~z;
      default:         res = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmp_pipe.sv
// Pipelined compare unit: subtract, derive flags, evaluate branch/set condition,
// with stall/flush control and a saturating count of true results.
module alu_cmp_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fun,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] true_cnt
);

  logic [WIDTH:0]   diff_full;
  logic [WIDTH-1:0] diff;
  flags_t           flags_in;

  always_comb begin
    diff_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    diff      = diff_full[WIDTH-1:0];
    flags_in  = {diff[WIDTH-1],
                 (diff == '0),
                 diff_full[WIDTH],
                 (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1])};
  end

  logic   ev_valid;
  flags_t ev_flags;
  logic [3:0] ev_fun;
  logic   ev_res;

  if (STAGES == 2) begin : g_two_stage
    logic       s1_valid_q;
    flags_t     s1_flags_q;
    logic [3:0] s1_fun_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_flags_q <= '0;
        s1_fun_q   <= '0;
      end else if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (!stall) begin
        s1_valid_q <= in_valid;
        s1_flags_q <= in_valid ? flags_in : '0;
        s1_fun_q   <= in_valid ? fun : '0;
      end
    end

    assign ev_valid = s1_valid_q;
    assign ev_flags = s1_flags_q;
    assign ev_fun   = s1_fun_q;
  end else begin : g_one_stage
    assign ev_valid = in_valid;
    assign ev_flags = flags_in;
    assign ev_fun   = fun;
  end

  cmp_cond_eval u_eval (
    .flags(ev_flags),
    .fun  (ev_fun),
    .res  (ev_res)
  );

  logic             out_valid_q;
  logic             res_q;
  flags_t           flags_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;

  assign load = ~stall & ~flush;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (load && ev_valid && ev_res && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      res_q       <= 1'b0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      // Flush only kills the valid bit; result and flag data are left stale.
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (!stall) begin
        out_valid_q <= ev_valid;
        res_q       <= ev_valid & ev_res;
        flags_q     <= ev_valid ? ev_flags : '0;
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = {{(WIDTH-1){1'b0}}, res_q & out_valid_q};
  assign flags     = flags_q;
  assign true_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Directed self-checking bench: two-stage unit (main cases, stall/flush) and a one-stage
// unit with a 2-bit counter (saturation, clear, reset on issue).
module tb_alu_cmp_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage instance
  logic        ra, va, sa, xa, ca;
  logic [31:0] aa, ba;
  logic [3:0]  fa;
  logic        ova;
  logic [31:0] outa;
  logic [3:0]  fla;
  logic [15:0] cnta;

  // One-stage instance with a tiny counter
  logic        rb, vb, sb, xb, cb;
  logic [31:0] ab, bb;
  logic [3:0]  fb;
  logic        ovb;
  logic [31:0] outb;
  logic [3:0]  flb;
  logic [1:0]  cntb;

  alu_cmp_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .reset(ra), .in_valid(va), .a(aa), .b(ba), .fun(fa),
    .stall(sa), .flush(xa), .cnt_clr(ca),
    .out_valid(ova), .out(outa), .flags(fla), .true_cnt(cnta)
  );

  alu_cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(rb), .in_valid(vb), .a(ab), .b(bb), .fun(fb),
    .stall(sb), .flush(xb), .cnt_clr(cb),
    .out_valid(ovb), .out(outb), .flags(flb), .true_cnt(cntb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [31:0] x, input logic [31:0] y, input logic [3:0] f);
    va = 1'b1;
    aa = x;
    ba = y;
    fa = f;
  endtask

  initial begin
    ra = 1'b1; va = 1'b0; sa = 1'b0; xa = 1'b0; ca = 1'b0; aa = '0; ba = '0; fa = '0;
    rb = 1'b1; vb = 1'b0; sb = 1'b0; xb = 1'b0; cb = 1'b0; ab = '0; bb = '0; fb = '0;
    tick;
    tick;
    ra = 1'b0;
    rb = 1'b0;
    check_eq("rst_ov2",   32'(ova),  32'd0);
    check_eq("rst_out2",  outa,      32'd0);
    check_eq("rst_fl2",   32'(fla),  32'd0);
    check_eq("rst_cnt2",  32'(cnta), 32'd0);
    check_eq("rst_ov1",   32'(ovb),  32'd0);
    check_eq("rst_cnt1",  32'(cntb), 32'd0);

    // EQ, two-cycle latency
    issue_a(32'd5, 32'd5, 4'b0001);
    tick;
    va = 1'b0;
    check_eq("eq_early_ov", 32'(ova), 32'd0);
    tick;
    check_eq("eq_ov",  32'(ova),  32'd1);
    check_eq("eq_out", outa,      32'd1);
    check_eq("eq_fl",  32'(fla),  32'h6);
    check_eq("eq_cnt", 32'(cnta), 32'd1);

    // -1 vs 1: signed LT true, unsigned LT false, back to back
    issue_a(32'hFFFF_FFFF, 32'd1, 4'b0010);
    tick;
    issue_a(32'hFFFF_FFFF, 32'd1, 4'b1010);
    tick;
    va = 1'b0;
    check_eq("slt_ov",  32'(ova), 32'd1);
    check_eq("slt_out", outa,     32'd1);
    check_eq("slt_fl",  32'(fla), 32'hA);
    tick;
    check_eq("ult_ov",  32'(ova),  32'd1);
    check_eq("ult_out", outa,      32'd0);
    check_eq("ult_cnt", 32'(cnta), 32'd2);

    // Signed overflow: 0x80000000 - 1
    issue_a(32'h8000_0000, 32'd1, 4'b0111);
    tick;
    issue_a(32'h8000_0000, 32'd1, 4'b1111);
    tick;
    va = 1'b0;
    check_eq("sgt_out", outa,     32'd0);
    check_eq("sgt_fl",  32'(fla), 32'h3);
    tick;
    check_eq("ugt_out", outa,      32'd1);
    check_eq("ugt_fl",  32'(fla),  32'h3);
    check_eq("ugt_cnt", 32'(cnta), 32'd3);

    // Unassigned code yields 0 even when Z is set
    issue_a(32'd9, 32'd9, 4'b0011);
    tick;
    va = 1'b0;
    tick;
    check_eq("rsv_ov",  32'(ova),  32'd1);
    check_eq("rsv_out", outa,      32'd0);
    check_eq("rsv_cnt", 32'(cnta), 32'd3);

    // Three EQ ops (third false), then stall, then flush under stall
    issue_a(32'd1, 32'd1, 4'b0001);
    tick;
    issue_a(32'd2, 32'd2, 4'b0001);
    tick;
    issue_a(32'd3, 32'd4, 4'b0001);
    tick;
    check_eq("pre_stall_cnt", 32'(cnta), 32'd5);
    sa = 1'b1;
    va = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      check_eq($sformatf("stall%0d_ov", i),  32'(ova),  32'd1);
      check_eq($sformatf("stall%0d_out", i), outa,      32'd1);
      check_eq($sformatf("stall%0d_fl", i),  32'(fla),  32'h6);
      check_eq($sformatf("stall%0d_cnt", i), 32'(cnta), 32'd5);
    end
    xa = 1'b1;
    tick;
    check_eq("flush_ov",  32'(ova), 32'd0);
    check_eq("flush_out", outa,     32'd0);
    sa = 1'b0;
    xa = 1'b0;
    tick;
    check_eq("post_flush_ov",  32'(ova),  32'd0);
    check_eq("post_flush_cnt", 32'(cnta), 32'd5);

    // Reset mid-flight on the two-stage unit discards the op
    issue_a(32'd5, 32'd5, 4'b0001);
    tick;
    va = 1'b0;
    ra = 1'b1;
    tick;
    ra = 1'b0;
    check_eq("mid_rst_ov",  32'(ova),  32'd0);
    check_eq("mid_rst_cnt", 32'(cnta), 32'd0);
    tick;
    check_eq("mid_rst_ov2", 32'(ova),  32'd0);

    // One-stage unit: saturating counter with CNT_W = 2
    vb = 1'b1; ab = 32'd0; bb = 32'd0; fb = 4'b0001;
    tick;
    tick;
    check_eq("sat_cnt2", 32'(cntb), 32'd2);
    tick;
    tick;
    tick;
    check_eq("sat_cnt5", 32'(cntb), 32'd3);
    check_eq("sat_out",  outb,      32'd1);
    cb = 1'b1;
    tick;
    check_eq("clr_cnt", 32'(cntb), 32'd0);
    check_eq("clr_out", outb,      32'd1);
    cb = 1'b0;
    vb = 1'b0;
    tick;

    // One-stage LE, single-cycle latency
    vb = 1'b1; ab = 32'd3; bb = 32'd7; fb = 4'b0110;
    tick;
    vb = 1'b0;
    check_eq("le_ov",  32'(ovb),  32'd1);
    check_eq("le_out", outb,      32'd1);
    check_eq("le_fl",  32'(flb),  32'h8);
    check_eq("le_cnt", 32'(cntb), 32'd1);

    // Reset on the issue cycle wins
    vb = 1'b1;
    rb = 1'b1;
    tick;
    rb = 1'b0;
    vb = 1'b0;
    check_eq("rst_issue_ov",  32'(ovb),  32'd0);
    check_eq("rst_issue_out", outb,      32'd0);
    check_eq("rst_issue_cnt", 32'(cntb), 32'd0);
    check_eq("rst_issue_fl",  32'(flb),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmp_pipe.md
Name: alu_cmp_pipe

Overview:
- Parametrised, pipelined compare unit for the MIPS pipeline.
- Computes a − b internally and derives N/Z/C/V from it.
- Evaluates a signed or unsigned branch/set condition and returns a zero-extended boolean plus the registered flags.
- Supports stall, flush and a saturating true-result counter for branch statistics.

Parameters:
- WIDTH, 32, operand and result width (≥ 2).
- STAGES, 2, pipeline depth: 1 = flags and evaluation in one registered stage; 2 = flag stage then evaluation stage.
- CNT_W, 16, width of the true-result counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and fun valid this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- fun  in  4  condition code; fun[3] = unsigned select.
- stall  in  1  hold all pipeline registers.
- flush  in  1  kill all in-flight operations.
- cnt_clr  in  1  clear the counter.
- out_valid  out  1  result valid.
- out  out  WIDTH  bit 0 = condition result, bits WIDTH−1:1 = 0.
- flags  out  4  {N, Z, C, V} of the operation producing `out`.
- true_cnt  out  CNT_W  count of valid true results.

Behaviour:
- Single clock `clk`. Reset is synchronous, active-high, port `reset`.
- Reset clears every register: out_valid = 0, out = 0, flags = 0, true_cnt = 0, all internal valid and data regs = 0.
- Arithmetic: d = a + ~b + 1, computed at WIDTH bits with carry-out C.
  - Z = (d == 0).
  - N = d[WIDTH−1].
  - V = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]).
  - C = 1 means no borrow (a ≥ b unsigned).
- Signed conditions (fun[3] = 0), indexed by fun[2:0]:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 LT: N^V
  - 101 LTZ: N^V (caller drives b = 0)
  - 110 LE: Z | (N^V)
  - 111 GT: ~Z & ~(N^V)
  - any other code: 0
- Unsigned conditions (fun[3] = 1): same fun[2:0] encoding, with LT/LTZ = ~C, LE = ~C | Z, GT = C & ~Z. NE and EQ are unchanged.
- STAGES = 2:
  - Stage 1 registers {Z, N, C, V, fun, valid} from the inputs.
  - Stage 2 registers out, flags and out_valid.
  - Latency is 2 cycles from the in_valid cycle to out_valid.
- STAGES = 1: out, flags and out_valid are registered directly from the inputs; latency is 1 cycle.
- Throughput is one op per cycle when not stalled.
- stall = 1:
  - Every pipeline register, including out, flags and out_valid, holds its value.
  - Inputs are not sampled; upstream must hold them.
  - The counter does not increment.
- flush = 1: all valid bits (stage 1 and out_valid) clear next cycle. Data regs may keep stale values.
  - flush has priority over stall.
  - flush does not clear out or flags data or true_cnt; out is still forced to 0 while out_valid = 0.
- Invalid slots: when in_valid = 0 the stage valid becomes 0 and the stage's out/flags are written with 0.
- true_cnt: increments by 1 on each clock edge where the output register is loaded (not stalled, not flushed) with a valid true result.
  - Saturates at 2^CNT_W − 1.
  - cnt_clr takes priority over increment and sets the counter to 0.
  - reset takes priority over cnt_clr.
- Reset mid-operation: all in-flight ops are discarded; out_valid = 0 on the cycle after reset.

Decomposition:
- Shared package alu_pkg: fun encoding constants (CMP_NE = 3'b000, CMP_EQ = 3'b001, CMP_LT = 3'b010, CMP_LTZ = 3'b101, CMP_LE = 3'b110, CMP_GT = 3'b111, CMP_UNS_BIT = 3) and the flag index constants (F_N = 3, F_Z = 2, F_C = 1, F_V = 0).
- One combinational sub-module, cmp_cond_eval (flags + fun → 1-bit result). It is reused by the branch unit.

Test Plan:
- WIDTH = 32, STAGES = 2. a = 5, b = 5, fun = 0001, in_valid one cycle → 2 cycles later out_valid = 1, out = 1, flags = 4'b0110 (Z = 1, C = 1), true_cnt = 1.
- a = 0xFFFFFFFF, b = 1:
  - fun = 0010 (signed LT) → out = 1.
  - next op, same operands, fun = 1010 (unsigned LT) → out = 0.
  - results arrive on consecutive cycles.
- Overflow case: a = 0x80000000, b = 1, fun = 0111 (signed GT) → V = 1, N = 0, out = 0. With fun = 1111 (unsigned GT) → out = 1.
- Stall and flush:
  - Issue 3 back-to-back EQ ops, then assert stall for 2 cycles → out, flags and out_valid frozen; counter unchanged.
  - Then flush with stall still high → out_valid = 0 next cycle; the in-flight op never appears.
- Counter saturation: CNT_W = 2, issue 5 true results → true_cnt = 3. Then assert cnt_clr together with a true result → true_cnt = 0.
- STAGES = 1, a = 3, b = 7, fun = 0110 (LE) → out = 1 one cycle later. Assert reset on the issue cycle → out_valid = 0 and true_cnt = 0 on the cycle after reset.
